// File: rtl/wb_pipe_stage.sv
// Writeback stage: sub-word load extraction, writeback source select and one held
// result register feeding the register file and forwarding. Optional macro: WB_RETIRE_CNT_EN.
module wb_pipe_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [XLEN-1:0]  in_mem_data,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [1:0]       in_mem_to_reg,
  input  logic [1:0]       in_load_size,
  input  logic             in_load_unsigned,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_reg_write,
  input  logic             flush,
  input  logic             rf_ready,
  output logic             out_valid,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [CNT_W-1:0] instret
);

  localparam int LB = $clog2(XLEN / 8);

  logic [LB-1:0]   lane_mask;
  logic [LB-1:0]   byte_off;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] low_mask;
  logic [XLEN-1:0] loaded;
  logic [XLEN-1:0] sel_data;
  logic            sign_bit;
  logic            held_reg_write;
  logic            xfer;
  logic            consume;

  assign in_ready = !out_valid | rf_ready;
  assign xfer     = in_valid & in_ready & !flush;
  assign consume  = out_valid & rf_ready;

  // Lane offset keeps only the address bits that matter for the access size;
  // a doubleword (or word at XLEN=32) always starts at lane 0.
  always_comb begin
    lane_mask = '0;
    low_mask  = '1;
    case (in_load_size)
      2'd0: begin
        lane_mask = '1;
        low_mask  = XLEN'(8'hFF);
      end
      2'd1: begin
        lane_mask = {LB{1'b1}} << 1;
        low_mask  = XLEN'(16'hFFFF);
      end
      2'd2: begin
        lane_mask = {LB{1'b1}} << 2;
        low_mask  = XLEN'(32'hFFFF_FFFF);
      end
      default: begin
        lane_mask = '0;
        low_mask  = '1;
      end
    endcase
    byte_off = in_alu_result[LB-1:0] & lane_mask;
    shifted  = in_mem_data >> {byte_off, 3'b000};
    case (in_load_size)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = 1'b0;
    endcase
    loaded = shifted & low_mask;
    if (!in_load_unsigned && sign_bit) loaded = loaded | ~low_mask;
  end

  always_comb begin
    case (in_mem_to_reg)
      2'd0:    sel_data = in_pc4;
      2'd1:    sel_data = loaded;
      default: sel_data = in_alu_result;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      held_reg_write <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
    end else if (xfer) begin
      out_valid      <= 1'b1;
      held_reg_write <= in_reg_write;
      rf_waddr       <= in_rd;
      rf_wdata       <= sel_data;
    end else if (consume || flush) begin
      out_valid <= 1'b0;
    end
  end

  assign rf_we = out_valid & held_reg_write & (rf_waddr != '0);

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (consume) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage (XLEN=32): a depth-1 scoreboard of expected held
// entries, pushed on modelled transfers and popped on modelled consumes.
module tb_wb_pipe_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc4, in_mem_data, in_alu_result;
  logic [1:0]  in_mem_to_reg, in_load_size;
  logic        in_load_unsigned;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        flush;
  logic        rf_ready;
  logic        out_valid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [63:0] instret;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] w;
    logic        we;
  } entry_t;

  entry_t      sb[$];
  logic        m_valid;
  logic [31:0] last_w;
  logic [4:0]  last_rd;
  logic [63:0] m_cnt;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  wb_pipe_stage #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc4(in_pc4), .in_mem_data(in_mem_data), .in_alu_result(in_alu_result),
    .in_mem_to_reg(in_mem_to_reg), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .flush(flush), .rf_ready(rf_ready), .out_valid(out_valid), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .instret(instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    if (m_valid && sb.size() > 0) begin
      chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(sb[0].w));
      chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(sb[0].rd));
      chk({tag, ".rf_we"}, 64'(rf_we), 64'(sb[0].we));
    end else begin
      chk({tag, ".rf_we_idle"}, 64'(rf_we), 64'd0);
      chk({tag, ".rf_wdata_hold"}, 64'(rf_wdata), 64'(last_w));
      chk({tag, ".rf_waddr_hold"}, 64'(rf_waddr), 64'(last_rd));
    end
`ifdef WB_RETIRE_CNT_EN
    chk({tag, ".instret"}, instret, m_cnt);
`else
    chk({tag, ".instret"}, instret, 64'd0);
`endif
  endtask

  // One clock: drive at edge+1, check in_ready mid-cycle, update model, check at next edge+1.
  task automatic step(input string tag, input logic v, input logic [1:0] sel,
                      input logic [31:0] pc4, input logic [31:0] mem, input logic [31:0] alu,
                      input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                      input logic rw, input logic rdy, input logic fl, input logic [31:0] exp_w);
    logic   exp_ready, cons, xf;
    entry_t e;
    in_valid = v; in_mem_to_reg = sel; in_pc4 = pc4; in_mem_data = mem;
    in_alu_result = alu; in_load_size = sz; in_load_unsigned = uns; in_rd = rd;
    in_reg_write = rw; rf_ready = rdy; flush = fl;
    #2;
    exp_ready = !m_valid || rdy;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_ready));
    cons = m_valid && rdy;
    xf   = v && exp_ready && !fl;
    if (cons) begin
      void'(sb.pop_front());
      m_cnt++;
    end
    if (fl) sb.delete();
    if (xf) begin
      e.rd = rd; e.w = exp_w; e.we = rw && (rd != 5'd0);
      sb.push_back(e);
      last_w = exp_w; last_rd = rd;
    end
    m_valid = xf ? 1'b1 : ((cons || fl) ? 1'b0 : m_valid);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic ld(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                    input logic uns, input logic [4:0] rd, input logic [31:0] exp_w);
    step(tag, 1'b1, 2'd1, 32'h0, 32'h80FF7F01, addr, sz, uns, rd, 1'b1, 1'b1, 1'b0, exp_w);
  endtask

  task automatic alu_op(input string tag, input logic v, input logic [31:0] alu,
                        input logic [4:0] rd, input logic rdy, input logic fl);
    step(tag, v, 2'd2, 32'h0, 32'h0, alu, 2'd2, 1'b0, rd, 1'b1, rdy, fl, alu);
  endtask

  initial begin
    m_valid = 1'b0; last_w = '0; last_rd = '0; m_cnt = '0;
    in_valid = 0; in_pc4 = 0; in_mem_data = 0; in_alu_result = 0; in_mem_to_reg = 0;
    in_load_size = 0; in_load_unsigned = 0; in_rd = 0; in_reg_write = 0;
    flush = 0; rf_ready = 1;
    rst = 1'b1;
    #1;
    check_outputs("reset");
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Sub-word loads from word 0x80FF7F01
    ld("lb_s",    32'h1002, 2'd0, 1'b0, 5'd5, 32'hFFFFFFFF);
    ld("lbu",     32'h1002, 2'd0, 1'b1, 5'd5, 32'h000000FF);
    ld("lb_s_l1", 32'h1001, 2'd0, 1'b0, 5'd6, 32'h0000007F);
    ld("lb_s_l3", 32'h1003, 2'd0, 1'b0, 5'd6, 32'hFFFFFF80);
    ld("lh_s",    32'h1002, 2'd1, 1'b0, 5'd7, 32'hFFFF80FF);
    ld("lhu",     32'h1002, 2'd1, 1'b1, 5'd7, 32'h000080FF);
    ld("lh_odd",  32'h1001, 2'd1, 1'b0, 5'd8, 32'h00007F01);
    ld("lw",      32'h1003, 2'd2, 1'b0, 5'd9, 32'h80FF7F01);
    ld("ld32",    32'h1002, 2'd3, 1'b1, 5'd9, 32'h80FF7F01);

    // Source select: PC4, ALU via select 3 and select 2
    step("sel_pc4", 1, 2'd0, 32'h104, 32'h80FF7F01, 32'h1000, 2'd0, 0, 5'd1, 1, 1, 0, 32'h104);
    step("sel_3",   1, 2'd3, 32'h104, 32'h80FF7F01, 32'hDEAD, 2'd0, 0, 5'd2, 1, 1, 0, 32'hDEAD);
    alu_op("sel_2", 1, 32'h1234_5678, 5'd3, 1, 0);

    // rd=0 occupies the slot without a write; reg_write=0 likewise
    alu_op("rd0", 1, 32'h55, 5'd0, 1, 0);
    step("nowr", 1, 2'd2, 0, 0, 32'h66, 2'd2, 0, 5'd7, 1'b0, 1, 0, 32'h66);

    // Stall three cycles with a pending input, then stream back-to-back and drain
    alu_op("st_a",  1, 32'hA0, 5'd10, 1, 0);
    alu_op("st_b0", 1, 32'hB0, 5'd11, 0, 0);
    alu_op("st_b1", 1, 32'hB0, 5'd11, 0, 0);
    alu_op("st_b2", 1, 32'hB0, 5'd11, 0, 0);
    alu_op("st_rel", 1, 32'hB0, 5'd11, 1, 0);
    alu_op("bb_c",  1, 32'hC0, 5'd12, 1, 0);
    alu_op("bb_d",  1, 32'hD0, 5'd13, 1, 0);
    alu_op("drain", 0, 32'hEE, 5'd14, 1, 0);
    alu_op("idle",  0, 32'hEF, 5'd15, 1, 0);

    // Flush: held entry with stall drops both; flush with consume still retires
    alu_op("fl_ld",   1, 32'hF0, 5'd16, 1, 0);
    alu_op("fl_kill", 1, 32'hF1, 5'd17, 0, 1);
    alu_op("fl_ld2",  1, 32'hF2, 5'd18, 1, 0);
    alu_op("fl_cons", 1, 32'hF3, 5'd19, 1, 1);
    alu_op("fl_after", 1, 32'hF4, 5'd20, 1, 0);

    // Async reset while stalled clears everything before any clock edge
    alu_op("rs_stall", 1, 32'h77, 5'd21, 0, 0);
    in_valid = 1'b1;
    rf_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    m_valid = 1'b0; last_w = '0; last_rd = '0; m_cnt = '0;
    check_outputs("rst_async");
    chk("rst_async.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_rst");
    alu_op("post_rst_x", 1, 32'h99, 5'd22, 1, 0);
    alu_op("post_rst_d", 0, 32'h0, 5'd0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
